// File: rtl/bb_pkg.sv
// bb_pkg: shared constants and state encodings for the bus-bridge UART receive path.
// The RX_PARITY state exists only when BB_RX_PARITY_EN is defined.
package bb_pkg;
    localparam logic [6:0] BB_HDR_SYNC   = 7'h55;
    localparam logic       BB_MODE_READ  = 1'b0;
    localparam logic       BB_MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef BB_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        FR_HDR,
        FR_ADDR,
        FR_DATA,
        FR_HOLD
    } frame_state_t;
endpackage

// File: rtl/bb_uart_rx_byte.sv
// bb_uart_rx_byte: synchronised 8N1 byte receiver; 8E1 when BB_RX_PARITY_EN is defined.
// Emits one-cycle rx_stb for a good byte and rx_err for a framing or parity fault.
module bb_uart_rx_byte
    import bb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       u_rx,
    output logic [7:0] rx_data,
    output logic       rx_stb,
    output logic       rx_err,
    output logic       rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_t st, st_n;
    logic s1, s2, s3;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_i, bit_n;
    logic [7:0] sh_n;
    logic stb_n, err_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {s1, s2, s3} <= 3'b111;
            st <= RX_IDLE;
            cnt <= '0;
            bit_i <= '0;
            rx_data <= '0;
            rx_stb <= 1'b0;
            rx_err <= 1'b0;
        end else begin
            {s1, s2, s3} <= {u_rx, s1, s2};
            st <= st_n;
            cnt <= cnt_n;
            bit_i <= bit_n;
            rx_data <= sh_n;
            rx_stb <= stb_n;
            rx_err <= err_n;
        end
    end

    always_comb begin
        st_n = st;
        cnt_n = cnt + 1'b1;
        bit_n = bit_i;
        sh_n = rx_data;
        stb_n = 1'b0;
        err_n = 1'b0;
        case (st)
            RX_IDLE: begin
                cnt_n = '0;
                if (s3 && !s2) st_n = RX_START;
            end
            RX_START: if (cnt == HALF) begin
                cnt_n = '0;
                bit_n = '0;
                st_n = s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt == FULL) begin
                cnt_n = '0;
                sh_n = {s2, rx_data[7:1]};
                bit_n = bit_i + 1'b1;
`ifdef BB_RX_PARITY_EN
                if (bit_i == 3'd7) st_n = RX_PARITY;
`else
                if (bit_i == 3'd7) st_n = RX_STOP;
`endif
            end
`ifdef BB_RX_PARITY_EN
            RX_PARITY: if (cnt == FULL) begin
                cnt_n = '0;
                err_n = s2 != ^rx_data;
                st_n = err_n ? RX_IDLE : RX_STOP;
            end
`endif
            RX_STOP: if (cnt == FULL) begin
                cnt_n = '0;
                st_n = RX_IDLE;
                stb_n = s2;
                err_n = !s2;
            end
            default: st_n = RX_IDLE;
        endcase
    end

    assign rx_busy = st != RX_IDLE;
endmodule

// File: rtl/bb_uart_frame_rx.sv
// bb_uart_frame_rx: assembles header/address/write-data bytes into one valid/ready bus request.
// Even-parity framing is enabled by defining BB_RX_PARITY_EN.
module bb_uart_frame_rx
    import bb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  u_rx,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_mode,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int NB = ADDR_WIDTH / 8;

    frame_state_t fs, fs_n;
    logic [7:0] rx_data, idx, idx_n;
    logic rx_stb, rx_err, rx_busy;
    logic mode_n, err_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] wdata_n;

    bb_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk(clk),
        .rstn(rstn),
        .u_rx(u_rx),
        .rx_data(rx_data),
        .rx_stb(rx_stb),
        .rx_err(rx_err),
        .rx_busy(rx_busy)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fs <= FR_HDR;
            idx <= '0;
            req_mode <= BB_MODE_READ;
            req_addr <= '0;
            req_wdata <= '0;
            frame_err <= 1'b0;
        end else begin
            fs <= fs_n;
            idx <= idx_n;
            req_mode <= mode_n;
            req_addr <= addr_n;
            req_wdata <= wdata_n;
            frame_err <= err_n;
        end
    end

    // Receiver errors always pulse frame_err; only ADDR/DATA abandon the frame on them.
    always_comb begin
        fs_n = fs;
        idx_n = idx;
        mode_n = req_mode;
        addr_n = req_addr;
        wdata_n = req_wdata;
        err_n = rx_err;
        case (fs)
            FR_HDR: if (rx_stb) begin
                if (rx_data[7:1] == BB_HDR_SYNC) begin
                    fs_n = FR_ADDR;
                    mode_n = rx_data[0];
                    addr_n = '0;
                    wdata_n = '0;
                    idx_n = '0;
                end else err_n = 1'b1;
            end
            FR_ADDR: if (rx_err) fs_n = FR_HDR;
            else if (rx_stb) begin
                addr_n = ADDR_WIDTH'({req_addr, rx_data});
                idx_n = idx + 1'b1;
                if (idx == 8'(NB - 1)) fs_n = req_mode == BB_MODE_WRITE ? FR_DATA : FR_HOLD;
            end
            FR_DATA: if (rx_err) fs_n = FR_HDR;
            else if (rx_stb) begin
                wdata_n = DATA_WIDTH'(rx_data);
                fs_n = FR_HOLD;
            end
            FR_HOLD: begin
                if (rx_stb) err_n = 1'b1;
                if (req_ready) fs_n = FR_HDR;
            end
            default: fs_n = FR_HDR;
        endcase
    end

    assign req_valid = fs == FR_HOLD;
    assign busy = fs != FR_HDR || rx_busy;
endmodule
